// File: rtl/spi_master_ctrl.sv
// SPI initiator: turns {cmd, payload} requests into SS_n/MOSI frames on clk
// and captures the MISO byte returned by read-data frames.
module spi_master_ctrl #(
  parameter int DATA_W     = 8,
  parameter int TURNAROUND = 1,
  parameter int IDLE_GAP   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        cmd,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  // state  | meaning
  // IDLE   | SS_n high, waiting for start
  // SELECT | k=0, routing bit cmd[1] on MOSI
  // SEND   | k=1..FRAME_W, frame shifted out MSB first
  // TURN   | read-data only, MOSI low while the slave prepares its byte
  // RECV   | read-data only, DATA_W MISO bits shifted in
  // GAP    | SS_n high for IDLE_GAP cycles, done on the first one
  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SEND,
    S_TURN,
    S_RECV,
    S_GAP
  } state_t;

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W);

  localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURNAROUND - 1);
  localparam logic [CNT_W-1:0] RECV_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(IDLE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [FRAME_W-1:0]  frame, frame_nxt;
  logic                is_rd, is_rd_nxt;
  logic [DATA_W-1:0]   rx_sh, rx_sh_nxt;
  logic [DATA_W-1:0]   rd_data_nxt;
  logic                busy_nxt, done_nxt, rd_valid_nxt, ss_n_nxt, mosi_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      frame    <= '0;
      is_rd    <= 1'b0;
      rx_sh    <= '0;
      rd_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      frame    <= frame_nxt;
      is_rd    <= is_rd_nxt;
      rx_sh    <= rx_sh_nxt;
      rd_data  <= rd_data_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      rd_valid <= rd_valid_nxt;
      SS_n     <= ss_n_nxt;
      MOSI     <= mosi_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    frame_nxt    = frame;
    is_rd_nxt    = is_rd;
    rx_sh_nxt    = rx_sh;
    rd_data_nxt  = rd_data;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    rd_valid_nxt = 1'b0;
    ss_n_nxt     = SS_n;
    mosi_nxt     = 1'b0;

    unique case (state)
      S_IDLE: begin
        ss_n_nxt = 1'b1;
        busy_nxt = 1'b0;
        if (start) begin
          frame_nxt = {cmd, wr_data};
          is_rd_nxt = (cmd == 2'b11);
          busy_nxt  = 1'b1;
          ss_n_nxt  = 1'b0;
          mosi_nxt  = cmd[1];
          state_nxt = S_SELECT;
        end
      end

      S_SELECT: begin
        mosi_nxt  = frame[FRAME_W-1];
        frame_nxt = frame << 1;
        cnt_nxt   = SEND_LAST;
        state_nxt = S_SEND;
      end

      S_SEND: begin
        if (cnt != '0) begin
          mosi_nxt  = frame[FRAME_W-1];
          frame_nxt = frame << 1;
          cnt_nxt   = cnt - CNT_ONE;
        end else if (is_rd) begin
          cnt_nxt   = TURN_LAST;
          state_nxt = S_TURN;
        end else begin
          ss_n_nxt  = 1'b1;
          done_nxt  = 1'b1;
          cnt_nxt   = GAP_LAST;
          state_nxt = S_GAP;
        end
      end

      S_TURN: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else begin
          cnt_nxt   = RECV_LAST;
          state_nxt = S_RECV;
        end
      end

      // MISO is only looked at here, so junk outside RECV cannot reach rd_data
      S_RECV: begin
        rx_sh_nxt = {rx_sh[DATA_W-2:0], MISO};
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else begin
          rd_data_nxt  = {rx_sh[DATA_W-2:0], MISO};
          ss_n_nxt     = 1'b1;
          done_nxt     = 1'b1;
          rd_valid_nxt = 1'b1;
          cnt_nxt      = GAP_LAST;
          state_nxt    = S_GAP;
        end
      end

      S_GAP: begin
        ss_n_nxt = 1'b1;
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else begin
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end

      default: begin
        ss_n_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: a behavioural SPI slave/RAM on the pins plus a
// request scoreboard checked at every frame end.
module tb_spi_master_ctrl;

  localparam int TA  = 1;
  localparam int GAP = 1;

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] data;
  } req_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  spi_master_ctrl #(
    .DATA_W    (8),
    .TURNAROUND(TA),
    .IDLE_GAP  (GAP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cmd     (cmd),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .SS_n    (SS_n),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard and reference model (updated from requests)
  req_t       exp_q[$];
  logic [7:0] m_mem[256];
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_rd = 8'h00;

  // slave (updated from decoded MOSI)
  logic [7:0] s_mem[256];
  logic [7:0] s_addr = 8'h00;
  logic [7:0] s_byte = 8'h00;

  int          mon_k = 0;
  int          mon_hi = 0;
  bit          mon_seen = 0;
  bit          chk_gap = 0;
  logic [31:0] mon_bits = '0;

  task automatic frame_end();
    req_t        e;
    logic [9:0]  fr;
    logic [31:0] exp_bits;
    int          exp_len;
    logic [1:0]  s_cmd;
    logic [7:0]  s_pay;
    chk("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      fr = {e.cmd, e.data};
      exp_bits = '0;
      exp_bits[0] = e.cmd[1];
      for (int i = 0; i < 10; i++) exp_bits[i+1] = fr[9-i];
      exp_len = (e.cmd == 2'b11) ? 19 + TA : 11;
      case (e.cmd)
        2'b00:   m_addr = e.data;
        2'b01:   m_mem[m_addr] = e.data;
        2'b10:   m_addr = e.data;
        default: m_rd = m_mem[m_addr];
      endcase
      chk("frame_len", 32'(mon_k), 32'(exp_len));
      chk("mosi_bits", mon_bits, exp_bits);
      chk("done", 32'(done), 32'd1);
      chk("rd_valid", 32'(rd_valid), 32'(e.cmd == 2'b11));
      chk("rd_data", 32'(rd_data), 32'(m_rd));
    end
    s_cmd = {mon_bits[1], mon_bits[2]};
    for (int i = 0; i < 8; i++) s_pay[7-i] = mon_bits[3+i];
    case (s_cmd)
      2'b00:   s_addr = s_pay;
      2'b01:   s_mem[s_addr] = s_pay;
      2'b10:   s_addr = s_pay;
      default: ;
    endcase
  endtask

  // slave + monitor: samples on the falling edge, drives MISO for the next rising edge
  always @(negedge clk) begin
    if (rst) begin
      mon_k = 0;
      mon_hi = 0;
      mon_seen = 0;
      MISO = 1'b0;
    end else if (!SS_n) begin
      if (mon_k == 0) begin
        if (mon_seen && chk_gap) chk("ss_gap", 32'(mon_hi), 32'(GAP + 1));
        mon_bits = '0;
        s_byte = s_mem[s_addr];
      end
      if (mon_k < 32) mon_bits[mon_k] = MOSI;
      if (mon_k >= 11 + TA && mon_k < 19 + TA) MISO = s_byte[18 + TA - mon_k];
      else MISO = 1'($urandom);
      mon_k++;
    end else begin
      MISO = 1'($urandom);
      if (mon_k != 0) begin
        frame_end();
        mon_k = 0;
        mon_hi = 0;
        mon_seen = 1;
      end else if (mon_seen && mon_hi == 1) begin
        chk("done_pulse", 32'(done), 32'd0);
      end
      if (mon_seen && mon_hi < GAP) chk("busy_gap", 32'(busy), 32'd1);
      if (mon_seen && mon_hi == GAP) chk("busy_idle", 32'(busy), 32'd0);
      mon_hi++;
    end
  end

  task automatic do_req(input logic [1:0] c, input logic [7:0] d, input bit hold);
    req_t r;
    @(negedge clk);
    cmd = c;
    wr_data = d;
    start = 1'b1;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    @(posedge clk);
    #1;
    chk("accept_busy", 32'(busy), 32'd1);
    r.cmd = c;
    r.data = d;
    exp_q.push_back(r);
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy && SS_n) break;
    end
    chk("idle_reached", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_pulse();
    #2 rst = 1'b1;
    #1;
    chk("rst_ss_n", 32'(SS_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    exp_q.delete();
    m_rd = 8'h00;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cmd = 2'b00;
    wr_data = 8'h00;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_ss_n", 32'(SS_n), 32'd1);
    chk("reset_mosi", 32'(MOSI), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);

    // start presented in the same cycle reset is released
    begin
      req_t r;
      cmd = 2'b00;
      wr_data = 8'h5A;
      start = 1'b1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("accept_at_release", 32'(busy), 32'd1);
      r.cmd = 2'b00;
      r.data = 8'h5A;
      exp_q.push_back(r);
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle();

    do_req(2'b01, 8'hA5, 0);
    wait_idle();

    do_req(2'b00, 8'h3C, 0);
    do_req(2'b01, 8'hC3, 0);
    do_req(2'b10, 8'h3C, 0);
    do_req(2'b11, 8'h00, 0);
    wait_idle();
    chk("rd_after_read", 32'(rd_data), 32'h0C3);

    // start pulsed during SEND must not create a frame
    do_req(2'b00, 8'h11, 0);
    repeat (3) @(negedge clk);
    cmd = 2'b11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cmd = 2'b00;
    wait_idle();

    do_req(2'b01, 8'h5F, 0);
    do_req(2'b00, 8'hFF, 0);
    wait_idle();
    chk("rd_hold", 32'(rd_data), 32'h0C3);

    // reset at k=5 of a write
    do_req(2'b00, 8'h77, 0);
    repeat (5) @(posedge clk);
    reset_pulse();
    chk("rd_cleared", 32'(rd_data), 32'd0);
    do_req(2'b00, 8'h3C, 0);
    do_req(2'b01, 8'h99, 0);
    do_req(2'b10, 8'h3C, 0);
    do_req(2'b11, 8'h00, 0);
    wait_idle();
    chk("rd_after_reset", 32'(rd_data), 32'h099);

    // reset in the middle of RECV discards the partial byte
    do_req(2'b11, 8'h00, 0);
    repeat (14) @(posedge clk);
    reset_pulse();
    chk("rd_recv_reset", 32'(rd_data), 32'd0);
    wait_idle();

    // back-to-back with start held; cmd changes while each frame is in flight
    do_req(2'b00, 8'h40, 1);
    @(negedge clk);
    #1 chk_gap = 1;
    do_req(2'b01, 8'hBE, 1);
    do_req(2'b10, 8'h40, 1);
    do_req(2'b11, 8'h00, 0);
    wait_idle();
    chk_gap = 0;
    chk("rd_b2b", 32'(rd_data), 32'h0BE);
    chk("q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
